// File: rtl/fir_pkg.sv
// Shared types and helpers for the polyphase interpolating FIR.
package fir_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MAC,
      S_ROUND,
      S_WAIT
   } state_t;

   function automatic int unsigned calc_out_div(input int unsigned mclk_rate,
                                                input int unsigned data_clk_in,
                                                input int unsigned l);
      return mclk_rate / (data_clk_in * l);
   endfunction

   // Round half-up of a Q(2*iw-2) accumulator back to Q1.(iw-1), then clamp to iw bits.
   function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                    input int unsigned iw);
      logic signed [63:0] r;
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      r     = (acc + (64'sd1 <<< (iw - 2))) >>> (iw - 1);
      max_v = (64'sd1 <<< (iw - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (iw - 1));
      if (r > max_v)
         r = max_v;
      else if (r < min_v)
         r = min_v;
      return r;
   endfunction

endpackage

// File: rtl/fir_mac.sv
// Signed IW x IW multiply-accumulate; clear restarts the sum with the current product.
module fir_mac
   import fir_pkg::*;
#(
   parameter int IW    = 16,
   parameter int ACC_W = 35
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    enable,
   input  logic signed [IW-1:0]    a,
   input  logic signed [IW-1:0]    b,
   output logic signed [ACC_W-1:0] acc
);

   logic signed [2*IW-1:0]  prod;
   logic signed [ACC_W-1:0] prod_ext;

   always_comb begin
      prod     = a * b;
      prod_ext = ACC_W'(prod);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         acc <= '0;
      else if (enable)
         acc <= clear ? prod_ext : acc + prod_ext;
   end

endmodule

// File: rtl/fir_interpolator.sv
// Polyphase interpolator: one input sample yields L output phases, OUT_DIV cycles apart.
// coefficients is flat: h[n] occupies bits [n*IW +: IW].
module fir_interpolator
   import fir_pkg::*;
#(
   parameter int IW          = 16,
   parameter int L           = 4,
   parameter int PHASE_TAPS  = 8,
   parameter int MCLK_RATE   = 53693175,
   parameter int DATA_CLK_IN = 48000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [IW*L*PHASE_TAPS-1:0] coefficients,
   input  logic [IW-1:0]              data_in,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [IW-1:0]              data_out,
   output logic                       out_valid,
   output logic [$clog2(L)-1:0]       out_phase,
   output logic                       overrun
);

   localparam int TAPS      = L * PHASE_TAPS;
   localparam int OUT_DIV   = int'(calc_out_div(MCLK_RATE, DATA_CLK_IN, L));
   localparam int ACC_W     = 2 * IW + $clog2(PHASE_TAPS);
   localparam int PW        = $clog2(L);
   localparam int TW        = (PHASE_TAPS > 1) ? $clog2(PHASE_TAPS) : 1;
   localparam int CW        = $clog2(OUT_DIV);
   // MAC + ROUND + WAIT must span exactly OUT_DIV cycles between phases.
   localparam int WAIT_LAST = OUT_DIV - PHASE_TAPS - 2;

   state_t                  state, state_next;
   logic signed [IW-1:0]    x [PHASE_TAPS];
   logic [TW-1:0]           tap;
   logic [PW-1:0]           phase;
   logic [CW-1:0]           wait_cnt;
   logic                    accept;
   logic signed [IW-1:0]    coef_sel;
   logic signed [IW-1:0]    x_sel;
   logic signed [ACC_W-1:0] acc;
   int unsigned             cidx;

   assign in_ready = (state == S_IDLE);
   assign accept   = in_valid && in_ready;

   always_comb begin
      cidx     = 32'(tap) * 32'(L) + 32'(phase);
      coef_sel = $signed(coefficients[cidx*IW +: IW]);
      x_sel    = x[tap];
   end

   fir_mac #(.IW(IW), .ACC_W(ACC_W)) u_mac (
      .clk    (clk),
      .reset  (reset),
      .clear  (tap == '0),
      .enable (state == S_MAC),
      .a      (x_sel),
      .b      (coef_sel),
      .acc    (acc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (accept) state_next = S_MAC;
         S_MAC:   if (tap == TW'(PHASE_TAPS - 1)) state_next = S_ROUND;
         S_ROUND: state_next = S_WAIT;
         S_WAIT: begin
            if (phase == PW'(L - 1))
               state_next = S_IDLE;
            else if (wait_cnt == CW'(WAIT_LAST))
               state_next = S_MAC;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned k = 0; k < PHASE_TAPS; k++)
            x[k] <= '0;
         tap       <= '0;
         phase     <= '0;
         wait_cnt  <= '0;
         data_out  <= '0;
         out_valid <= 1'b0;
         out_phase <= '0;
         overrun   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (in_valid && !in_ready)
            overrun <= 1'b1;
         if (accept) begin
            x[0] <= data_in;
            for (int unsigned k = 1; k < PHASE_TAPS; k++)
               x[k] <= x[k-1];
            phase <= '0;
         end
         tap <= (state == S_MAC && tap != TW'(PHASE_TAPS - 1)) ? tap + 1'b1 : '0;
         case (state)
            S_ROUND: begin
               data_out  <= IW'(round_sat(64'(acc), IW));
               out_valid <= 1'b1;
               out_phase <= phase;
               wait_cnt  <= '0;
            end
            S_WAIT: begin
               wait_cnt <= wait_cnt + 1'b1;
               if (state_next == S_MAC)
                  phase <= phase + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
